// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the two-player score keeper.
package score_keeper_pkg;

    // Game phases: still playing, or one of the two players has won.
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        P1WON = 2'd1,
        P2WON = 2'd2
    } game_state_t;

    // Width of each player's score register.
    localparam int SCORE_W = 4;

    // Default point total that ends a game.
    localparam int WIN_SCORE_DEF = 3;

    // A point request is only usable when exactly one player pressed this cycle.
    function automatic logic lone_rise(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/score_keeper_rise_detect.sv
// Rising-edge detector for one debounced button level.
// The history bit resets high, so a button already held at reset is not seen as a press.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic hist_r;

    // Remember the level sampled at the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= 1'b1;
        end else begin
            hist_r <= din;
        end
    end

    assign rise = din & ~hist_r;

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper: counts debounced button presses, applies a lockout
// after each accepted point and stops the game when a player reaches WIN_SCORE.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int LOCKOUT_CYC = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               NEWGAME,
    input  logic               P1PT,
    input  logic               P2PT,
    output logic [SCORE_W-1:0] P1TTLSCR,
    output logic [SCORE_W-1:0] P2TTLSCR,
    output logic               GAMEOVER,
    output logic               LOCKED
);

    localparam int                 LCW    = $clog2(LOCKOUT_CYC + 1);
    localparam logic [SCORE_W-1:0] WIN_V  = SCORE_W'(WIN_SCORE);
    localparam logic [LCW-1:0]     LOCK_V = LCW'(LOCKOUT_CYC);

    // A 4-bit score can only represent win totals of 1..15.
    generate
        if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
            $error("score_keeper: WIN_SCORE must be within 1..15");
        end
    endgenerate

    game_state_t    state_r;
    logic [LCW-1:0] lock_cnt_r;
    logic [LCW-1:0] lock_nxt_s;
    logic           p1_rise_s;
    logic           p2_rise_s;
    logic           p1_acc_s;
    logic           p2_acc_s;

    rise_detect u_p1_rise (
        .clk  (CLK),
        .rst  (RST),
        .din  (P1PT),
        .rise (p1_rise_s)
    );

    rise_detect u_p2_rise (
        .clk  (CLK),
        .rst  (RST),
        .din  (P2PT),
        .rise (p2_rise_s)
    );

    // Decide whether a lone press is accepted as a point this cycle.
    always_comb begin
        p1_acc_s = 1'b0;
        p2_acc_s = 1'b0;
        if ((state_r == PLAY) && (lock_cnt_r == '0) && lone_rise(p1_rise_s, p2_rise_s)) begin
            p1_acc_s = p1_rise_s & (P1TTLSCR < WIN_V);
            p2_acc_s = p2_rise_s & (P2TTLSCR < WIN_V);
        end else begin
            p1_acc_s = 1'b0;
            p2_acc_s = 1'b0;
        end
    end

    // Next lockout count: run down while active, reload on an accepted point.
    always_comb begin
        lock_nxt_s = lock_cnt_r;
        if (lock_cnt_r != '0) begin
            lock_nxt_s = lock_cnt_r - LCW'(1);
        end else if (p1_acc_s || p2_acc_s) begin
            lock_nxt_s = LOCK_V;
        end else begin
            lock_nxt_s = '0;
        end
    end

    // Game FSM with registered scores, game-over flag and lockout state.
    always_ff @(posedge CLK) begin
        if (RST || NEWGAME) begin
            state_r    <= PLAY;
            P1TTLSCR   <= '0;
            P2TTLSCR   <= '0;
            GAMEOVER   <= 1'b0;
            LOCKED     <= 1'b0;
            lock_cnt_r <= '0;
        end else begin
            lock_cnt_r <= lock_nxt_s;
            LOCKED     <= (lock_nxt_s != '0);
            case (state_r)
                PLAY: begin
                    if (p1_acc_s) begin
                        P1TTLSCR <= P1TTLSCR + SCORE_W'(1);
                        if (P1TTLSCR == (WIN_V - SCORE_W'(1))) begin
                            state_r  <= P1WON;
                            GAMEOVER <= 1'b1;
                        end
                    end else if (p2_acc_s) begin
                        P2TTLSCR <= P2TTLSCR + SCORE_W'(1);
                        if (P2TTLSCR == (WIN_V - SCORE_W'(1))) begin
                            state_r  <= P2WON;
                            GAMEOVER <= 1'b1;
                        end
                    end
                end
                P1WON, P2WON: begin
                    GAMEOVER <= 1'b1;
                end
                default: begin
                    state_r  <= PLAY;
                    GAMEOVER <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a game-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_score_keeper;

    localparam int WIN  = 3;
    localparam int LOCK = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       NEWGAME = 1'b0;
    logic       P1PT = 1'b0;
    logic       P2PT = 1'b0;
    logic [3:0] P1TTLSCR;
    logic [3:0] P2TTLSCR;
    logic       GAMEOVER;
    logic       LOCKED;

    int tests = 0;
    int fails = 0;

    // Reference model state, kept in plain game terms.
    int m_s1 = 0;
    int m_s2 = 0;
    int m_lock = 0;
    bit m_over = 1'b0;
    bit m_prev1 = 1'b1;
    bit m_prev2 = 1'b1;
    bit m_valid = 1'b0;

    always #5 CLK = ~CLK;

    score_keeper #(.WIN_SCORE(WIN), .LOCKOUT_CYC(LOCK)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .NEWGAME  (NEWGAME),
        .P1PT     (P1PT),
        .P2PT     (P2PT),
        .P1TTLSCR (P1TTLSCR),
        .P2TTLSCR (P2TTLSCR),
        .GAMEOVER (GAMEOVER),
        .LOCKED   (LOCKED)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Game rules applied at every rising clock edge.
    always @(posedge CLK) begin
        bit r1;
        bit r2;
        if (RST) begin
            m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 1'b0;
            m_prev1 = 1'b1; m_prev2 = 1'b1;
            m_valid = 1'b1;
        end else begin
            r1 = P1PT && !m_prev1;
            r2 = P2PT && !m_prev2;
            if (NEWGAME) begin
                m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 1'b0;
            end else if (m_lock > 0) begin
                m_lock = m_lock - 1;
            end else if (!m_over && (r1 != r2)) begin
                if (r1) m_s1 = m_s1 + 1;
                else    m_s2 = m_s2 + 1;
                m_lock = LOCK;
                m_over = (m_s1 == WIN) || (m_s2 == WIN);
            end
            m_prev1 = P1PT;
            m_prev2 = P2PT;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            check("model_p1", 32'(P1TTLSCR), 32'(m_s1));
            check("model_p2", 32'(P2TTLSCR), 32'(m_s2));
            check("model_gameover", 32'(GAMEOVER), 32'(m_over));
            check("model_locked", 32'(LOCKED), 32'(m_lock != 0));
        end
    end

    task automatic step(input bit p1, input bit p2, input bit ng, input bit rst);
        P1PT = p1; P2PT = p2; NEWGAME = ng; RST = rst;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        // Reset state.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_p1", 32'(P1TTLSCR), 32'd0);
        check("rst_p2", 32'(P2TTLSCR), 32'd0);
        check("rst_gameover", 32'(GAMEOVER), 32'd0);
        check("rst_locked", 32'(LOCKED), 32'd0);
        idle(1);

        // Three spaced P1 presses win the game.
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, 0);
            check("p1_count", 32'(P1TTLSCR), 32'(k));
            check("p1_gameover", 32'(GAMEOVER), 32'(k == 3));
            idle(6);
        end
        check("p1_win_p2", 32'(P2TTLSCR), 32'd0);

        // Presses after the win are ignored.
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0);
            idle(2);
        end
        check("won_p2_hold", 32'(P2TTLSCR), 32'd0);
        check("won_gameover", 32'(GAMEOVER), 32'd1);
        check("won_p1_hold", 32'(P1TTLSCR), 32'd3);

        // NEWGAME wins over a simultaneous press; held button must be re-pressed.
        step(1, 0, 1, 0);
        check("ng_p1", 32'(P1TTLSCR), 32'd0);
        check("ng_gameover", 32'(GAMEOVER), 32'd0);
        check("ng_locked", 32'(LOCKED), 32'd0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        check("ng_held_p1", 32'(P1TTLSCR), 32'd0);
        idle(1);
        step(1, 0, 0, 0);
        check("ng_repress_p1", 32'(P1TTLSCR), 32'd1);
        check("ng_repress_locked", 32'(LOCKED), 32'd1);
        idle(6);

        // Second press during lockout is dropped; lockout spans 4 cycles.
        step(0, 1, 0, 0);
        n = int'(LOCKED);
        idle(1);
        n += int'(LOCKED);
        step(0, 1, 0, 0);
        n += int'(LOCKED);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0);
            n += int'(LOCKED);
        end
        check("lock_p2", 32'(P2TTLSCR), 32'd1);
        check("lock_cycles", 32'(n), 32'd4);

        // Simultaneous presses cancel out.
        step(1, 1, 0, 0);
        check("both_p1", 32'(P1TTLSCR), 32'd1);
        check("both_p2", 32'(P2TTLSCR), 32'd1);
        check("both_locked", 32'(LOCKED), 32'd0);
        idle(2);

        // Reset mid-lockout at 2/1 with P2 held high.
        step(1, 0, 0, 0);
        check("pre_rst_p1", 32'(P1TTLSCR), 32'd2);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        check("rst_mid_p1", 32'(P1TTLSCR), 32'd0);
        check("rst_mid_p2", 32'(P2TTLSCR), 32'd0);
        check("rst_mid_locked", 32'(LOCKED), 32'd0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
        check("rst_held_p2", 32'(P2TTLSCR), 32'd0);
        idle(1);
        step(0, 1, 0, 0);
        check("rst_repress_p2", 32'(P2TTLSCR), 32'd1);

        // P2 goes on to win.
        idle(6);
        step(0, 1, 0, 0);
        idle(6);
        step(0, 1, 0, 0);
        check("p2_win_score", 32'(P2TTLSCR), 32'd3);
        check("p2_win_gameover", 32'(GAMEOVER), 32'd1);
        idle(6);
        step(0, 1, 0, 0);
        check("p2_win_cap", 32'(P2TTLSCR), 32'd3);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
